// File: rtl/eth_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet frame demultiplexer:
//   - Ethernet header field widths (destination/source MAC, ethertype)
//   - demux FSM state encoding
//   - saturation limit of the optional discarded-frame counter
// ----------------------------------------------------------------------------
package eth_pkg;

    localparam int ETH_MAC_W  = 48;
    localparam int ETH_TYPE_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } demux_state_t;

    localparam logic [15:0] DROP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/eth_demux_out_reg.sv
// ----------------------------------------------------------------------------
// eth_demux_out_reg
// Single-stream output register plus a one-entry skid register. The upstream
// ready is produced one cycle early (o_ready_early) so that the owner can
// register it; the skid entry absorbs the one beat that may arrive in the
// cycle the sink stalls.
//
// Handshake: a beat moves on a port when valid and ready are both 1 at the
// rising edge of clk. i_valid must already be qualified by the registered
// upstream ready; valid never depends combinationally on ready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties both slots)
//   i_valid/i_data  accepted input beat
//   o_ready_early   value the upstream ready register should take next cycle
//   o_valid/o_data  output register contents
//   i_ready         sink ready for the beat currently in the output register
// ----------------------------------------------------------------------------
module eth_demux_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready_early,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    // Keep accepting while the output drains, or while there is guaranteed
    // room: skid empty and the output register is not being filled now.
    assign o_ready_early = i_ready || (!r_skid_valid && (!r_out_valid || !i_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || i_ready) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= i_valid;
                r_skid_data  <= i_data;
            end else begin
                r_out_valid <= i_valid;
                r_out_data  <= i_data;
            end
        end else if (i_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/eth_demux.sv
// ----------------------------------------------------------------------------
// eth_demux
// Routes one Ethernet frame (header + AXI-stream payload) from a single input
// to one of M_COUNT outputs. enable/drop/select are sampled when the header is
// accepted and held for the whole frame. drop=1 or an out-of-range select
// discards the frame: the input is consumed and nothing is emitted.
//
// Handshake: every valid/ready pair transfers when both are 1 at the rising
// edge of clk; valid never waits on ready, and held data stays stable until
// the transfer.
//
// Optional feature: define ETH_DEMUX_DROP_COUNT_EN to add drop_count[15:0],
// a saturating count of discarded frames.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_eth_hdr_*                  input header (valid/ready, MACs, ethertype)
//   s_eth_payload_axis_*         input payload stream (tuser[0] = frame error)
//   m_eth_hdr_*                  per-port header valid/ready, replicated fields
//   m_eth_payload_axis_*         per-port payload valid/ready, replicated data
//   enable, drop, select         frame routing controls
//   drop_count                   discarded-frame counter (optional)
//   o_dbg_state                  current FSM state
// ----------------------------------------------------------------------------
module eth_demux
    import eth_pkg::*;
#(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int USER_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_eth_hdr_valid,
    output logic                             s_eth_hdr_ready,
    input  logic [ETH_MAC_W-1:0]             s_eth_dest_mac,
    input  logic [ETH_MAC_W-1:0]             s_eth_src_mac,
    input  logic [ETH_TYPE_W-1:0]            s_eth_type,
    input  logic [DATA_WIDTH-1:0]            s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_eth_payload_axis_tkeep,
    input  logic                             s_eth_payload_axis_tvalid,
    output logic                             s_eth_payload_axis_tready,
    input  logic                             s_eth_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0]            s_eth_payload_axis_tuser,
    output logic [M_COUNT-1:0]               m_eth_hdr_valid,
    input  logic [M_COUNT-1:0]               m_eth_hdr_ready,
    output logic [M_COUNT*ETH_MAC_W-1:0]     m_eth_dest_mac,
    output logic [M_COUNT*ETH_MAC_W-1:0]     m_eth_src_mac,
    output logic [M_COUNT*ETH_TYPE_W-1:0]    m_eth_type,
    output logic [M_COUNT*DATA_WIDTH-1:0]    m_eth_payload_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]    m_eth_payload_axis_tkeep,
    output logic [M_COUNT-1:0]               m_eth_payload_axis_tvalid,
    input  logic [M_COUNT-1:0]               m_eth_payload_axis_tready,
    output logic [M_COUNT-1:0]               m_eth_payload_axis_tlast,
    output logic [M_COUNT*USER_WIDTH-1:0]    m_eth_payload_axis_tuser,
    input  logic                             enable,
    input  logic                             drop,
    input  logic [$clog2(M_COUNT)-1:0]       select,
`ifdef ETH_DEMUX_DROP_COUNT_EN
    output logic [15:0]                      drop_count,
`endif
    output demux_state_t                     o_dbg_state
);

    localparam int SEL_W = $clog2(M_COUNT);
    localparam int PAY_W = SEL_W + DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

    demux_state_t            r_state;
    demux_state_t            w_state_next;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_discard;
    logic                    r_hdr_valid;
    logic [ETH_MAC_W-1:0]    r_dest_mac;
    logic [ETH_MAC_W-1:0]    r_src_mac;
    logic [ETH_TYPE_W-1:0]   r_type;
    logic                    r_pay_ready;

    logic                    w_in_discard;
    logic                    w_discard_next;
    logic                    w_hdr_xfer;
    logic                    w_hdr_busy;
    logic                    w_pay_xfer;
    logic                    w_pay_push;
    logic                    w_ready_early;
    logic [KEEP_WIDTH-1:0]   w_keep_in;
    logic [PAY_W-1:0]        w_pay_in;
    logic [PAY_W-1:0]        w_pay_out;
    logic                    w_out_valid;
    logic                    w_out_ready;
    logic [SEL_W-1:0]        w_out_sel;
    logic [DATA_WIDTH-1:0]   w_out_tdata;
    logic [KEEP_WIDTH-1:0]   w_out_tkeep;
    logic                    w_out_tlast;
    logic [USER_WIDTH-1:0]   w_out_tuser;

    assign w_in_discard = drop || (int'(select) >= M_COUNT);

    // r_sel only changes on a header accept, which requires the previous
    // header to be gone, so it also addresses the pending header.
    assign w_hdr_busy      = r_hdr_valid && !m_eth_hdr_ready[r_sel];
    assign s_eth_hdr_ready = !rst && (r_state == ST_IDLE) && enable && !w_hdr_busy;
    assign w_hdr_xfer      = s_eth_hdr_valid && s_eth_hdr_ready;

    assign w_pay_xfer = s_eth_payload_axis_tvalid && r_pay_ready;
    assign w_pay_push = w_pay_xfer && !r_discard;

    assign w_discard_next = w_hdr_xfer ? w_in_discard : r_discard;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_hdr_xfer) w_state_next = ST_FRAME;
            ST_FRAME: if (w_pay_xfer && s_eth_payload_axis_tlast) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_discard   <= 1'b0;
            r_hdr_valid <= 1'b0;
            r_pay_ready <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_discard <= w_discard_next;
            // Discarded frames are swallowed without touching the skid logic.
            r_pay_ready <= (w_state_next == ST_FRAME) && (w_discard_next || w_ready_early);
            if (w_hdr_xfer) r_sel <= select;
            if (w_hdr_xfer && !w_in_discard) r_hdr_valid <= 1'b1;
            else if (m_eth_hdr_ready[r_sel]) r_hdr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hdr_xfer) begin
            r_dest_mac <= s_eth_dest_mac;
            r_src_mac  <= s_eth_src_mac;
            r_type     <= s_eth_type;
        end
    end

    assign w_keep_in = (KEEP_ENABLE != 0) ? s_eth_payload_axis_tkeep : {KEEP_WIDTH{1'b1}};

    // The destination port travels with each beat so beats still queued from
    // the previous frame keep their port after the next header is accepted.
    assign w_pay_in = {r_sel, s_eth_payload_axis_tdata, w_keep_in,
                       s_eth_payload_axis_tlast, s_eth_payload_axis_tuser};

    eth_demux_out_reg #(
        .WIDTH (PAY_W)
    ) u_out_reg (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (w_pay_push),
        .i_data        (w_pay_in),
        .o_ready_early (w_ready_early),
        .o_valid       (w_out_valid),
        .o_data        (w_pay_out),
        .i_ready       (w_out_ready)
    );

    assign {w_out_sel, w_out_tdata, w_out_tkeep, w_out_tlast, w_out_tuser} = w_pay_out;
    assign w_out_ready = m_eth_payload_axis_tready[w_out_sel];

    assign s_eth_payload_axis_tready = r_pay_ready;

    assign m_eth_hdr_valid = r_hdr_valid ? (M_COUNT'(1) << r_sel) : '0;
    assign m_eth_dest_mac  = {M_COUNT{r_dest_mac}};
    assign m_eth_src_mac   = {M_COUNT{r_src_mac}};
    assign m_eth_type      = {M_COUNT{r_type}};

    assign m_eth_payload_axis_tvalid = w_out_valid ? (M_COUNT'(1) << w_out_sel) : '0;
    assign m_eth_payload_axis_tdata  = {M_COUNT{w_out_tdata}};
    assign m_eth_payload_axis_tkeep  = {M_COUNT{w_out_tkeep}};
    assign m_eth_payload_axis_tlast  = {M_COUNT{w_out_tlast}};
    assign m_eth_payload_axis_tuser  = {M_COUNT{w_out_tuser}};

    assign o_dbg_state = r_state;

`ifdef ETH_DEMUX_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= 16'd0;
        end else if (w_hdr_xfer && w_in_discard && (r_drop_count != DROP_COUNT_MAX)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_eth_demux.sv
// ----------------------------------------------------------------------------
// tb_eth_demux
// Bench for eth_demux with default parameters (4 ports, 8-bit payload, tkeep
// forced to ones). Frames come from a table of records; expected headers and
// beats are queued when driven and compared when an output port transfers.
// ----------------------------------------------------------------------------
module tb_eth_demux;
    import eth_pkg::*;

    typedef struct {
        logic [1:0] sel;
        logic       drp;
        int         len;
        logic [7:0] first;
        logic       gaps;
        int         abort_at;
        logic       exp_out;
        logic [1:0] exp_port;
        logic [3:0] exp_hdr_vec;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          s_eth_hdr_valid;
    logic          s_eth_hdr_ready;
    logic [47:0]   s_eth_dest_mac;
    logic [47:0]   s_eth_src_mac;
    logic [15:0]   s_eth_type;
    logic [7:0]    s_tdata;
    logic [0:0]    s_tkeep;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [0:0]    s_tuser;
    logic [3:0]    m_hdr_valid;
    logic [3:0]    m_hdr_ready;
    logic [191:0]  m_dest_mac;
    logic [191:0]  m_src_mac;
    logic [63:0]   m_type;
    logic [31:0]   m_tdata;
    logic [3:0]    m_tkeep;
    logic [3:0]    m_tvalid;
    logic [3:0]    m_tready;
    logic [3:0]    m_tlast;
    logic [3:0]    m_tuser;
    logic          enable;
    logic          drop;
    logic [1:0]    select;
    demux_state_t  dbg_state;
`ifdef ETH_DEMUX_DROP_COUNT_EN
    logic [15:0]   drop_count;
    int            exp_drops = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int in_beats = 0;
    logic cur_drop = 1'b0;
    logic prev_stall_push = 1'b0;

    logic [11:0]  exp_q[$];
    logic [113:0] hdr_q[$];

    frame_vec_t vecs[11];

    eth_demux dut (
        .clk                        (clk),
        .rst                        (rst),
        .s_eth_hdr_valid            (s_eth_hdr_valid),
        .s_eth_hdr_ready            (s_eth_hdr_ready),
        .s_eth_dest_mac             (s_eth_dest_mac),
        .s_eth_src_mac              (s_eth_src_mac),
        .s_eth_type                 (s_eth_type),
        .s_eth_payload_axis_tdata   (s_tdata),
        .s_eth_payload_axis_tkeep   (s_tkeep),
        .s_eth_payload_axis_tvalid  (s_tvalid),
        .s_eth_payload_axis_tready  (s_tready),
        .s_eth_payload_axis_tlast   (s_tlast),
        .s_eth_payload_axis_tuser   (s_tuser),
        .m_eth_hdr_valid            (m_hdr_valid),
        .m_eth_hdr_ready            (m_hdr_ready),
        .m_eth_dest_mac             (m_dest_mac),
        .m_eth_src_mac              (m_src_mac),
        .m_eth_type                 (m_type),
        .m_eth_payload_axis_tdata   (m_tdata),
        .m_eth_payload_axis_tkeep   (m_tkeep),
        .m_eth_payload_axis_tvalid  (m_tvalid),
        .m_eth_payload_axis_tready  (m_tready),
        .m_eth_payload_axis_tlast   (m_tlast),
        .m_eth_payload_axis_tuser   (m_tuser),
        .enable                     (enable),
        .drop                       (drop),
        .select                     (select),
`ifdef ETH_DEMUX_DROP_COUNT_EN
        .drop_count                 (drop_count),
`endif
        .o_dbg_state                (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [11:0]  got_b;
        logic [11:0]  exp_b;
        logic [113:0] got_h;
        logic [113:0] exp_h;
        if (rst) begin
            prev_stall_push = 1'b0;
        end else begin
            if (m_tvalid != 4'd0) check("tvalid_onehot", 128'($countones(m_tvalid) <= 1), 128'd1);
            for (int p = 0; p < 4; p++) begin
                if (m_tvalid[p] && m_tready[p]) begin
                    got_b = {p[1:0], m_tdata[p*8 +: 8], m_tlast[p], m_tuser[p]};
                    check("tkeep_ones", m_tkeep[p], 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL beat_unexpected: got %0h expected none", got_b);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("beat", got_b, exp_b);
                    end
                end
                if (m_hdr_valid[p] && m_hdr_ready[p]) begin
                    got_h = {p[1:0], m_dest_mac[p*48 +: 48], m_src_mac[p*48 +: 48], m_type[p*16 +: 16]};
                    if (hdr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL hdr_unexpected: got %0h expected none", got_h);
                    end else begin
                        exp_h = hdr_q.pop_front();
                        check("hdr", got_h, exp_h);
                    end
                end
            end
            // A beat accepted while the output is stalled must drop input ready.
            if (prev_stall_push) check("tready_backpressure", s_tready, 0);
            prev_stall_push = s_tvalid && s_tready && !cur_drop && ((m_tvalid & ~m_tready) != 4'd0);
            if (s_tvalid && s_tready) in_beats++;
        end
    end

    // ---------------- driver ----------------
    task automatic send_frame(input frame_vec_t v);
        logic [63:0] r64;
        logic [7:0]  d;
        logic        u;
        int          guard;
        int          exp_acc;
        in_beats = 0;
        cur_drop = v.drp;
        r64 = {$urandom(), $urandom()};
        s_eth_dest_mac = r64[47:0];
        r64 = {$urandom(), $urandom()};
        s_eth_src_mac = r64[47:0];
        s_eth_type = 16'($urandom());
        select = v.sel;
        drop = v.drp;
        s_eth_hdr_valid = 1'b1;
        // Offer the first beat alongside the header; it must wait.
        s_tvalid = 1'b1;
        s_tdata = v.first;
        s_tlast = (v.len == 1);
        s_tuser = 1'b0;
        if (v.exp_out) hdr_q.push_back({v.exp_port, s_eth_dest_mac, s_eth_src_mac, s_eth_type});
        guard = 0;
        @(negedge clk);
        while (!s_eth_hdr_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL hdr_timeout: got no s_eth_hdr_ready expected one within 100 cycles");
            s_eth_hdr_valid = 1'b0;
            s_tvalid = 1'b0;
            return;
        end
        check("idle_tready", s_tready, 0);
        @(posedge clk);
        #1;
        s_eth_hdr_valid = 1'b0;
        check("hdr_valid_vec", m_hdr_valid, v.exp_hdr_vec);
        // Controls must be ignored for the rest of the frame.
        select = 2'($urandom_range(0, 3));
        drop = 1'($urandom_range(0, 1));
        for (int b = 0; b < v.len; b++) begin
            if (b == v.abort_at) break;
            if (v.gaps && ($urandom_range(0, 2) == 0)) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            d = v.first + 8'(b);
            u = 1'($urandom_range(0, 1));
            s_tvalid = 1'b1;
            s_tdata = d;
            s_tlast = (b == v.len - 1);
            s_tuser = u;
            s_tkeep = 1'b0;
            if (v.exp_out) exp_q.push_back({v.exp_port, d, s_tlast, u});
            guard = 0;
            @(negedge clk);
            while (!s_tready && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            if (guard >= 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat_timeout: got no s_tready expected one within 200 cycles");
                s_tvalid = 1'b0;
                return;
            end
            if (v.drp) check("drop_tready_immediate", guard, 0);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        exp_acc = (v.abort_at < v.len) ? v.abort_at : v.len;
        check("beats_accepted", in_beats, exp_acc);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        n_errors++;
        $display("FAIL watchdog: got no end of test expected finish within 300000 time units");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic bp_pat[4];
        int   guard;
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        //          sel    drp   len first  gaps abort out  port   hdr_vec
        vecs[0]  = '{2'd2, 1'b0, 3, 8'h01, 1'b0, 99, 1'b1, 2'd2, 4'b0100};
        vecs[1]  = '{2'd0, 1'b0, 4, 8'h10, 1'b0, 99, 1'b1, 2'd0, 4'b0001};
        vecs[2]  = '{2'd3, 1'b0, 5, 8'h20, 1'b0, 99, 1'b1, 2'd3, 4'b1000};
        vecs[3]  = '{2'd1, 1'b1, 4, 8'h30, 1'b0, 99, 1'b0, 2'd0, 4'b0000};
        vecs[4]  = '{2'd1, 1'b0, 1, 8'h40, 1'b0, 99, 1'b1, 2'd1, 4'b0010};
        vecs[5]  = '{2'd0, 1'b0, 6, 8'h50, 1'b1, 99, 1'b1, 2'd0, 4'b0001};
        vecs[6]  = '{2'd3, 1'b1, 2, 8'h60, 1'b1, 99, 1'b0, 2'd0, 4'b0000};
        vecs[7]  = '{2'd2, 1'b0, 2, 8'hF0, 1'b1, 99, 1'b1, 2'd2, 4'b0100};
        vecs[8]  = '{2'd1, 1'b0, 8, 8'h80, 1'b0, 99, 1'b1, 2'd1, 4'b0010};
        vecs[9]  = '{2'd1, 1'b0, 5, 8'hA0, 1'b0, 2,  1'b1, 2'd1, 4'b0010};
        vecs[10] = '{2'd1, 1'b0, 5, 8'hC0, 1'b0, 99, 1'b1, 2'd1, 4'b0010};

        // reset
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac = '0;
        s_eth_src_mac = '0;
        s_eth_type = '0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = '0;
        m_hdr_ready = 4'hF;
        m_tready = 4'hF;
        enable = 1'b0;
        drop = 1'b0;
        select = 2'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hdr_valid", m_hdr_valid, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tready", s_tready, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_hdr_ready_disabled", s_eth_hdr_ready, 0);
`ifdef ETH_DEMUX_DROP_COUNT_EN
        check("rst_drop_count", drop_count, 0);
`endif

        // enable=0 holds off a pending header
        s_eth_hdr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("disabled_hdr_ready", s_eth_hdr_ready, 0);
        end
        check("disabled_state", dbg_state, ST_IDLE);
        @(posedge clk);
        #1;
        s_eth_hdr_valid = 1'b0;
        enable = 1'b1;

        // table of frames, back to back
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i]);
`ifdef ETH_DEMUX_DROP_COUNT_EN
            if (vecs[i].drp) exp_drops++;
            check("drop_count", drop_count, exp_drops);
`endif
        end

        // port 1 sink toggles 1,0,0,1 during an 8-beat frame
        fork
            send_frame(vecs[8]);
            begin
                for (int i = 0; i < 40; i++) begin
                    m_tready[1] = bp_pat[i % 4];
                    @(posedge clk);
                    #1;
                end
                m_tready[1] = 1'b1;
            end
        join

        // reset after beat 2 of 5
        send_frame(vecs[9]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hdr_q.delete();
        check("midrst_hdr_valid", m_hdr_valid, 0);
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_tready", s_tready, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        send_frame(vecs[10]);

        // drain
        guard = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("drain_beats", exp_q.size(), 0);
        check("drain_hdrs", hdr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_demux.md
ETH_DEMUX -- requirements
Module: eth_demux

Interface
REQ-001 SHALL have parameter M_COUNT, default 4: number of output ports, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: payload tdata width.
REQ-003 SHALL have parameter KEEP_ENABLE, default (DATA_WIDTH>8): tkeep used; when 0, tkeep is forced to all ones.
REQ-004 SHALL have parameter KEEP_WIDTH, default (DATA_WIDTH/8): tkeep width.
REQ-005 SHALL have parameter USER_WIDTH, default 1: tuser width.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-008 SHALL have port s_eth_hdr_valid  in  1  input header valid.
REQ-009 SHALL have port s_eth_hdr_ready  out  1  input header accepted.
REQ-010 SHALL have port s_eth_dest_mac  in  48  destination MAC.
REQ-011 SHALL have port s_eth_src_mac  in  48  source MAC.
REQ-012 SHALL have port s_eth_type  in  16  ethertype.
REQ-013 SHALL have port s_eth_payload_axis_tdata  in  DATA_WIDTH  payload data.
REQ-014 SHALL have port s_eth_payload_axis_tkeep  in  KEEP_WIDTH  byte enables.
REQ-015 SHALL have port s_eth_payload_axis_tvalid  in  1  payload valid.
REQ-016 SHALL have port s_eth_payload_axis_tready  out  1  payload ready.
REQ-017 SHALL have port s_eth_payload_axis_tlast  in  1  last payload beat of frame.
REQ-018 SHALL have port s_eth_payload_axis_tuser  in  USER_WIDTH  sideband; bit 0 is the frame error flag.
REQ-019 SHALL have port m_eth_hdr_valid  out  M_COUNT  per-port header valid.
REQ-020 SHALL have port m_eth_hdr_ready  in  M_COUNT  per-port header ready.
REQ-021 SHALL have port m_eth_dest_mac  out  M_COUNT*48  replicated destination MAC.
REQ-022 SHALL have port m_eth_src_mac  out  M_COUNT*48  replicated source MAC.
REQ-023 SHALL have port m_eth_type  out  M_COUNT*16  replicated ethertype.
REQ-024 SHALL have port m_eth_payload_axis_tdata  out  M_COUNT*DATA_WIDTH  replicated payload data.
REQ-025 SHALL have port m_eth_payload_axis_tkeep  out  M_COUNT*KEEP_WIDTH  replicated byte enables.
REQ-026 SHALL have port m_eth_payload_axis_tvalid  out  M_COUNT  per-port payload valid.
REQ-027 SHALL have port m_eth_payload_axis_tready  in  M_COUNT  per-port payload ready.
REQ-028 SHALL have port m_eth_payload_axis_tlast  out  M_COUNT  replicated last flag.
REQ-029 SHALL have port m_eth_payload_axis_tuser  out  M_COUNT*USER_WIDTH  replicated sideband.
REQ-030 SHALL have port enable  in  1  frame acceptance enable, sampled at header accept.
REQ-031 SHALL have port drop  in  1  discard frame, sampled at header accept.
REQ-032 SHALL have port select  in  $clog2(M_COUNT)  output port, sampled at header accept.

Function
REQ-033 SHALL implement two states: IDLE and FRAME. In IDLE, s_eth_hdr_ready=1 only when enable=1 and the output header register is empty or being accepted; a header transfer latches select and drop and moves to FRAME. In FRAME, s_eth_hdr_ready=0.
REQ-034 SHALL register the header with 1-cycle latency: it asserts only m_eth_hdr_valid[select], and holds valid and fields stable until m_eth_hdr_ready[select]=1.
REQ-035 SHALL pass payload through an output register plus one-entry skid register with 1-cycle latency. s_eth_payload_axis_tready SHALL be registered and SHALL be 1 only in FRAME with the skid register empty. Only m_eth_payload_axis_tvalid[select] asserts. Throughput is 1 beat/cycle while the sink is ready; there is no bubble between back-to-back frames.
REQ-036 SHALL return to IDLE on the tlast beat transfer on the input side. Payload offered while in IDLE SHALL not be accepted.
REQ-037 SHALL treat drop=1, or select>=M_COUNT, as a discard: the header is accepted with no m_eth_hdr_valid, payload is accepted with tready=1 every FRAME cycle, and nothing is output.
REQ-038 SHALL ignore changes on enable, drop or select during FRAME. When s_eth_hdr_valid and payload tvalid arrive in the same cycle, header acceptance takes priority.

Reset
REQ-039 rst SHALL, synchronously and mid-frame, force IDLE. All m_*valid, s_eth_hdr_ready and s_eth_payload_axis_tready go to 0 and the skid register empties. The data outputs are don't-care. The partial frame is lost.

Configuration
REQ-040 Macro ETH_DEMUX_DROP_COUNT_EN: when defined, the block SHALL add output drop_count [15:0]. It increments once per discarded frame on header accept, saturates at 16'hFFFF, and resets to 0. When undefined, the port and logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-041 Header field widths (MAC 48, type 16) SHALL live in the shared package eth_pkg. The payload output/skid register SHALL be the sub-module eth_demux_out_reg, one instance shared across ports, with valid fanned out by the latched select.

Verification
REQ-042 Scenario: select=2, enable=1, 3-beat frame 0x01,0x02,0x03, all sinks ready -> header only on port 2 one cycle later; 3 beats only on port 2, tlast on 0x03.
REQ-043 Scenario: frames to select 0 then 3 back-to-back -> port 0 gets frame A, port 3 gets frame B; no beat crosses ports; select changes mid-frame are ignored.
REQ-044 Scenario: drop=1, 4-beat frame -> no m valid asserted, 4 input beats accepted; drop_count goes 0->1 when the macro is defined.
REQ-045 Scenario: port 1 tready toggles 1,0,0,1 during an 8-beat frame -> 8 beats delivered in order, none lost or duplicated; input tready falls within 1 cycle of backpressure.
REQ-046 Scenario: rst for 1 cycle after beat 2 of 5 -> all valids 0 next cycle; a new frame to port 1 afterwards is delivered intact.
